// File: rtl/cal_dac_spi_tx.sv
// cal_dac_spi_tx: streams 16-bit calibration samples from a small FIFO into an
// external serial DAC at a fixed sample rate. Each sample tick sends one
// 24-bit SPI frame {CMD_BYTE, sample}, MSB first, with SCLK idle low and data
// captured by the DAC on the rising SCLK edge.
// Optional feature macro: CAL_DAC_LDAC_EN adds the dac_ldac_n port and an
// LDAC strobe phase after each frame. Without it the DAC updates on cs_n rise.
module cal_dac_spi_tx #(
  parameter int          SCLK_DIV   = 2,
  parameter int          SAMPLE_DIV = 1000,
  parameter logic [7:0]  CMD_BYTE   = 8'h30,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [15:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          dac_sclk,
  output logic                          dac_mosi,
  output logic                          dac_cs_n,
`ifdef CAL_DAC_LDAC_EN
  output logic                          dac_ldac_n,
`endif
  output logic                          busy,
  output logic                          underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(SAMPLE_DIV + 1);
  localparam int DW = $clog2(SCLK_DIV + 2);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
`ifdef CAL_DAC_LDAC_EN
    LDAC,
`endif
    DONE
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [FIFO_DEPTH-1:0][15:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        full, empty, push, pop;
  logic [15:0]                 head;

  // ---------------------------------------------------------------- tick
  logic [TW-1:0] tick_cnt;
  logic          tick;

  // ---------------------------------------------------------------- frame
  state_t        state;
  logic [22:0]   shreg;        // frame bits 22..0; bit 23 goes straight to mosi
  logic [15:0]   last_sample;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic          cs_n_r, sclk_r, mosi_r, underrun_r;
  logic [15:0]   next_sample;
  logic [23:0]   next_frame;
`ifdef CAL_DAC_LDAC_EN
  logic          ldac_n_r;
`endif

  assign fifo_level  = wr_ptr - rd_ptr;
  assign full        = (fifo_level == PW'(FIFO_DEPTH));
  assign empty       = (fifo_level == '0);
  assign s_ready     = !full;
  assign push        = s_valid && s_ready;
  assign head        = mem[rd_ptr[AW-1:0]];
  assign pop         = tick && (state == IDLE) && !empty;
  // An empty FIFO repeats the previous sample so the DAC holds its level.
  assign next_sample = empty ? last_sample : head;
  assign next_frame  = {CMD_BYTE, next_sample};

  // Sample storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  // FIFO pointers; extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sample-rate divider; tick is a registered one-clk pulse on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (!enable) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TW'(SAMPLE_DIV - 1)) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
      tick     <= 1'b0;
    end
  end

  // SPI frame FSM with registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      last_sample <= 16'h8000;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      cs_n_r      <= 1'b1;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      underrun_r  <= 1'b0;
`ifdef CAL_DAC_LDAC_EN
      ldac_n_r    <= 1'b1;
`endif
    end else begin
      // A tick is lost if a frame is still running, or stale if nothing queued.
      underrun_r <= tick && ((state != IDLE) || empty);
      unique case (state)
        IDLE: begin
          cs_n_r <= 1'b1;
          sclk_r <= 1'b0;
          if (tick) begin
            shreg       <= next_frame[22:0];
            mosi_r      <= next_frame[23];
            last_sample <= next_sample;
            cs_n_r      <= 1'b0;
            div_cnt     <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DW'(SCLK_DIV - 1)) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_r  <= 1'b1;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        SHIFT: begin
          if (div_cnt != DW'(SCLK_DIV - 1)) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (sclk_r) begin
              // Falling edge: present the next bit while SCLK is low.
              sclk_r <= 1'b0;
              if (bit_cnt != 5'd23) begin
                mosi_r <= shreg[22];
                shreg  <= {shreg[21:0], 1'b0};
              end
            end else if (bit_cnt == 5'd23) begin
              cs_n_r <= 1'b1;
              mosi_r <= 1'b0;
              state  <= DONE;
            end else begin
              sclk_r  <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        DONE: begin
          cs_n_r <= 1'b1;
          mosi_r <= 1'b0;
`ifdef CAL_DAC_LDAC_EN
          div_cnt <= '0;
          state   <= LDAC;
`else
          state   <= IDLE;
`endif
        end
`ifdef CAL_DAC_LDAC_EN
        // One idle clk, SCLK_DIV clks of ldac_n low, one recovery clk.
        LDAC: begin
          if (div_cnt == '0) begin
            ldac_n_r <= 1'b0;
            div_cnt  <= div_cnt + DW'(1);
          end else if (div_cnt == DW'(SCLK_DIV)) begin
            ldac_n_r <= 1'b1;
            div_cnt  <= div_cnt + DW'(1);
          end else if (div_cnt == DW'(SCLK_DIV + 1)) begin
            div_cnt  <= '0;
            state    <= IDLE;
          end else begin
            div_cnt  <= div_cnt + DW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign dac_cs_n   = cs_n_r;
  assign dac_sclk   = sclk_r;
  assign dac_mosi   = mosi_r;
  assign underrun   = underrun_r;
  assign busy       = (state != IDLE);
`ifdef CAL_DAC_LDAC_EN
  assign dac_ldac_n = ldac_n_r;
`endif

endmodule

// File: tb/tb_cal_dac_spi_tx.sv
// tb_cal_dac_spi_tx: directed sequence with random sample values, checked
// against a queue-based model of the sample stream and SPI frame timing.
module tb_cal_dac_spi_tx;
  localparam int SD  = 2;
  localparam int SPD = 200;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, dac_sclk, dac_mosi, dac_cs_n, busy, underrun;
  logic [2:0]  fifo_level;
`ifdef CAL_DAC_LDAC_EN
  logic        dac_ldac_n;
`endif

  cal_dac_spi_tx #(.SCLK_DIV(SD), .SAMPLE_DIV(SPD), .CMD_BYTE(8'h30), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .fifo_level(fifo_level), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi),
    .dac_cs_n(dac_cs_n),
`ifdef CAL_DAC_LDAC_EN
    .dac_ldac_n(dac_ldac_n),
`endif
    .busy(busy), .underrun(underrun));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0, fails = 0;

  // Observed SPI traffic, sampled on the falling clk edge.
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_mosi = 1'b0, prev_ldac = 1'b1;
  logic [23:0] cap;
  int          nbits, lowcnt, rise_cyc, busy_fall_cyc, ldac_fall_cyc, ldac_rise_cyc;
  int          ur_cnt = 0, mosi_viol = 0;
  logic [23:0] frames[$];
  int          fbits[$], flow[$], ffall[$], ur_cyc[$];

  always @(negedge clk) begin
    if (!dac_cs_n && prev_cs) begin ffall.push_back(cyc); nbits = 0; cap = '0; lowcnt = 0; end
    if (!dac_cs_n) lowcnt++;
    if (!dac_cs_n && dac_sclk && dac_mosi !== prev_mosi) mosi_viol++;
    if (!dac_cs_n && dac_sclk && !prev_sclk) begin cap = {cap[22:0], dac_mosi}; nbits++; end
    if (dac_cs_n && !prev_cs) begin
      rise_cyc = cyc; frames.push_back(cap); fbits.push_back(nbits); flow.push_back(lowcnt);
    end
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    if (underrun) begin ur_cnt++; ur_cyc.push_back(cyc); end
`ifdef CAL_DAC_LDAC_EN
    if (!dac_ldac_n && prev_ldac) ldac_fall_cyc = cyc;
    if (dac_ldac_n && !prev_ldac) ldac_rise_cyc = cyc;
    prev_ldac = dac_ldac_n;
`endif
    prev_cs = dac_cs_n; prev_sclk = dac_sclk; prev_busy = busy; prev_mosi = dac_mosi;
  end

  // Reference model: queue of accepted samples and the held sample.
  logic [15:0] mq[$];
  logic [15:0] mlast = 16'h8000;
  int          exp_ur = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, output int acc);
    int t = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && t < 600) begin @(negedge clk); t++; end
    chk("push_accept", (t < 600), 1);
    @(negedge clk);
    acc = cyc;
    s_valid = 1'b0;
    mq.push_back(d);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames.size() < n && t < n * SPD + 400) begin @(negedge clk); t++; end
    chk("frame_arrival", (frames.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (4) @(negedge clk);
    while (busy && t < 400) begin @(negedge clk); t++; end
    chk("idle_wait", busy, 0);
  endtask

  task automatic check_frame(input string tag);
    logic [15:0] s;
    if (frames.size() == 0) begin chk({tag, "_present"}, frames.size(), 1); return; end
    if (mq.size() > 0) s = mq.pop_front();
    else begin s = mlast; exp_ur++; end
    mlast = s;
    chk({tag, "_data"}, frames.pop_front(), {8'h30, s});
    chk({tag, "_bits"}, fbits.pop_front(), 24);
    chk({tag, "_cs_low"}, flow.pop_front(), 49 * SD);
  endtask

  task automatic clear_obs();
    frames.delete(); fbits.delete(); flow.delete(); ffall.delete(); ur_cyc.delete();
  endtask

  initial begin
    int en, acc, n, p, k;
    logic ps;
    // Reset state
    @(negedge clk);
    chk("rst_cs_n", dac_cs_n, 1);
    chk("rst_sclk", dac_sclk, 0);
    chk("rst_mosi", dac_mosi, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
`ifdef CAL_DAC_LDAC_EN
    chk("rst_ldac_n", dac_ldac_n, 1);
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Empty FIFO: midscale frames, one underrun per tick
    enable = 1'b1; en = cyc;
    wait_frames(2);
    chk("ur_first_lat", (ur_cyc.size() > 0) ? ur_cyc[0] - en : -1, SPD + 1);
    chk("ur_spacing", (ur_cyc.size() > 1) ? ur_cyc[1] - ur_cyc[0] : -1, SPD);
    chk("empty_fall_lat", (ffall.size() > 0) ? ffall[0] - en : -1, SPD + 1);
    check_frame("empty0");
    check_frame("empty1");
    chk("ur_count_empty", ur_cnt, exp_ur);
    enable = 1'b0;
    wait_idle();
    clear_obs();

    // Single known sample, latency and frame shape
    push(16'hA5C3, acc);
    repeat (2) @(negedge clk);
    enable = 1'b1; en = cyc;
    wait_frames(1);
    chk("a5c3_fall_lat", (ffall.size() > 0) ? ffall[0] - en : -1, SPD + 1);
    check_frame("a5c3");
    enable = 1'b0;
    repeat (10) @(negedge clk);
`ifdef CAL_DAC_LDAC_EN
    chk("ldac_start", ldac_fall_cyc - rise_cyc, 2);
    chk("ldac_width", ldac_rise_cyc - ldac_fall_cyc, SD);
    chk("ldac_busy_fall", busy_fall_cyc - ldac_rise_cyc, 1);
`else
    chk("done_busy_fall", busy_fall_cyc - rise_cyc, 1);
`endif
    chk("ur_count_a5c3", ur_cnt, exp_ur);
    wait_idle();
    clear_obs();

    // Five back-to-back pushes into a depth-4 FIFO
    for (int i = 0; i < 4; i++) push(16'($urandom), acc);
    chk("full_s_ready", s_ready, 0);
    chk("full_level", fifo_level, 4);
    enable = 1'b1; en = cyc;
    push(16'($urandom), acc);
    chk("fifth_accept_lat", acc - en, SPD + 2);
    wait_frames(5);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) check_frame("order");
    chk("order_level", fifo_level, 0);
    chk("ur_count_order", ur_cnt, exp_ur);
    wait_idle();
    clear_obs();

    // Random rounds mixing queued samples and held-sample repeats
    for (int r = 0; r < 3; r++) begin
      p = $urandom_range(0, 2);
      k = p + 1;
      for (int i = 0; i < p; i++) push(16'($urandom), acc);
      enable = 1'b1;
      wait_frames(k);
      enable = 1'b0;
      for (int i = 0; i < k; i++) check_frame("rand");
      wait_idle();
      clear_obs();
    end
    chk("ur_count_rand", ur_cnt, exp_ur);

    // Reset in the middle of a frame
    push(16'($urandom), acc);
    push(16'($urandom), acc);
    enable = 1'b1;
    n = 0; ps = 1'b0; k = 0;
    while (n < 10 && k < 2 * SPD) begin
      @(posedge clk); #1;
      if (dac_sclk && !ps) n++;
      ps = dac_sclk; k++;
    end
    chk("sclk_rise_seen", n, 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", dac_cs_n, 1);
    chk("midrst_sclk", dac_sclk, 0);
    repeat (2) @(negedge clk);
    clear_obs();
    mq.delete(); mlast = 16'h8000;
    rst_n = 1'b1; en = cyc;
    @(negedge clk);
    chk("postrst_level", fifo_level, 0);
    chk("postrst_s_ready", s_ready, 1);
    wait_frames(1);
    chk("postrst_fall_lat", (ffall.size() > 0) ? ffall[0] - en : -1, SPD + 1);
    check_frame("postrst");
    enable = 1'b0;
    wait_idle();
    chk("ur_count_final", ur_cnt, exp_ur);
    chk("mosi_stable_high", mosi_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
